// File: rtl/mult_unit.sv
// Sequential shift-add multiplier for MULT/MULTU: one add-and-shift step per clock
// through an internal ripple-carry adder, then a sign fix-up before writing hi/lo.

module ripple_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

module mult_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CNT_W-1:0]   count;
  logic               neg;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] result;

  // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude.
  assign abs_a   = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign abs_b   = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  assign addend  = acc_lo[0] ? mag_a : '0;
  assign product = {acc_hi, acc_lo};
  assign result  = neg ? -product : product;

  ripple_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      mag_a  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      count  <= '0;
      neg    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag_a  <= abs_a;
            acc_hi <= '0;
            acc_lo <= abs_b;
            neg    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // The adder carry-out becomes the new top bit, so no product bit is lost.
          {acc_hi, acc_lo} <= {cout, sum, acc_lo[WIDTH-1:1]};
          count            <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          hi    <= result[2*WIDTH-1:WIDTH];
          lo    <= result[WIDTH-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Directed self-checking bench for mult_unit: latency, signed/unsigned products,
// ignored start while busy, asynchronous abort, and back-to-back operation.

module tb_mult_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  mult_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One multiply: start held for a single edge, operands scrambled afterwards,
  // then wait (bounded) for done. lat counts edges after the accepting edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                               output int lat, output int busy_cycles, output logic [63:0] mid);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; is_signed = s;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op_a = ~a; op_b = 32'h5a5a_a5a5; is_signed = ~s;
    lat = 0; busy_cycles = 0; mid = '0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      if (lat == 16) mid = {hi, lo};
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int          lat;
    int          bcyc;
    int          pulses;
    logic [63:0] mid;
    logic [63:0] prev;
    logic [31:0] bb_a [3];
    logic [31:0] bb_b [3];
    logic        bb_s [3];
    logic [63:0] bb_p [3];

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    #12;
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(32'd3, 32'd5, 1'b0, lat, bcyc, mid);
    checkOutput("multu_3x5_latency", lat, 33);
    checkOutput("multu_3x5_busy_cycles", bcyc, 33);
    checkOutput("multu_3x5_hold_run", mid, 64'd0);
    checkOutput("multu_3x5_result", {hi, lo}, 64'h0000_0000_0000_000F);
    checkOutput("multu_3x5_done_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    checkOutput("multu_3x5_done_one_cycle", {63'd0, done}, 64'd0);

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bcyc, mid);
    checkOutput("multu_max_hold_run", mid, 64'h0000_0000_0000_000F);
    checkOutput("multu_max_result", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    applyStimulus(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, lat, bcyc, mid);
    checkOutput("mult_m3x5_latency", lat, 33);
    checkOutput("mult_m3x5_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, bcyc, mid);
    checkOutput("mult_m1xm1_result", {hi, lo}, 64'h0000_0000_0000_0001);

    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, lat, bcyc, mid);
    checkOutput("mult_min_sq_result", {hi, lo}, 64'h4000_0000_0000_0000);

    applyStimulus(32'h0000_0000, 32'h8000_0000, 1'b1, lat, bcyc, mid);
    checkOutput("mult_0xmin_result", {hi, lo}, 64'h0000_0000_0000_0000);

    // Start while busy: the 7x9 request lands mid-run and must be dropped.
    @(negedge clk);
    start = 1'b1; op_a = 32'd2; op_b = 32'd2; is_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; op_a = 32'd7; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("busy_start_done_seen", {63'd0, done}, 64'd1);
    checkOutput("busy_start_result", {hi, lo}, 64'h0000_0000_0000_0004);
    pulses = 0;
    repeat (45) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("busy_start_no_second_done", pulses, 0);
    checkOutput("busy_start_idle", {63'd0, busy}, 64'd0);
    checkOutput("busy_start_hold", {hi, lo}, 64'h0000_0000_0000_0004);

    // Asynchronous reset in the middle of a 6x7 run.
    @(negedge clk);
    start = 1'b1; op_a = 32'd6; op_b = 32'd7; is_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_hilo", {hi, lo}, 64'd0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) pulses++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("abort_no_done", pulses, 0);
    applyStimulus(32'd6, 32'd7, 1'b0, lat, bcyc, mid);
    checkOutput("after_abort_latency", lat, 33);
    checkOutput("after_abort_result", {hi, lo}, 64'h0000_0000_0000_002A);

    // Back-to-back: start held high, operands for the next multiply presented
    // during each done cycle, garbage presented while running.
    bb_a[0] = 32'h0001_0000; bb_b[0] = 32'h0001_0000; bb_s[0] = 1'b0; bb_p[0] = 64'h0000_0001_0000_0000;
    bb_a[1] = 32'hFFFF_FFFE; bb_b[1] = 32'h0000_0003; bb_s[1] = 1'b1; bb_p[1] = 64'hFFFF_FFFF_FFFF_FFFA;
    bb_a[2] = 32'h1234_5678; bb_b[2] = 32'h0000_0010; bb_s[2] = 1'b0; bb_p[2] = 64'h0000_0001_2345_6780;
    prev = 64'h0000_0000_0000_002A;
    @(negedge clk);
    start = 1'b1; op_a = bb_a[0]; op_b = bb_b[0]; is_signed = bb_s[0];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      op_a = $urandom; op_b = $urandom; is_signed = ~bb_s[k];
      lat = 0; mid = '0;
      while (!done && lat < 40) begin
        if (lat == 16) mid = {hi, lo};
        @(negedge clk);
        lat++;
      end
      checkOutput($sformatf("b2b_%0d_latency", k), lat, 33);
      checkOutput($sformatf("b2b_%0d_hold_run", k), mid, prev);
      checkOutput($sformatf("b2b_%0d_result", k), {hi, lo}, bb_p[k]);
      prev = bb_p[k];
      if (k < 2) begin
        op_a = bb_a[k+1]; op_b = bb_b[k+1]; is_signed = bb_s[k+1];
      end else begin
        start = 1'b0;
      end
    end
    repeat (5) @(negedge clk);
    checkOutput("final_idle", {63'd0, busy}, 64'd0);
    checkOutput("final_hold", {hi, lo}, 64'h0000_0001_2345_6780);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
